// File: rtl/pong_ball_ctrl_if.sv
// Ball-controller signal bundle: paddle/serve/strobe inputs and ball/score outputs.
interface pong_ball_ctrl_if;
    logic       strobe_i;
    logic       serve_i;
    logic [9:0] lpad_y_i;
    logic [9:0] rpad_y_i;
    logic [9:0] ball_x_o;
    logic [9:0] ball_y_o;
    logic [3:0] score_l_o;
    logic [3:0] score_r_o;
    logic       hit_o;
    logic       miss_o;
    logic       game_over_o;

    modport slave (
        input  strobe_i, serve_i, lpad_y_i, rpad_y_i,
        output ball_x_o, ball_y_o, score_l_o, score_r_o, hit_o, miss_o, game_over_o
    );

    modport master (
        output strobe_i, serve_i, lpad_y_i, rpad_y_i,
        input  ball_x_o, ball_y_o, score_l_o, score_r_o, hit_o, miss_o, game_over_o
    );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball-motion engine: moves the ball per strobe, bounces, detects misses, keeps score.
// Optional macro BALL_SPEEDUP_EN: paddle hits raise the speed up to MAX_SPEED, a miss restores SPEED.
module pong_ball_ctrl #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned PADDLE_W   = 8,
    parameter int unsigned PADDLE_H   = 64,
    parameter int unsigned PADDLE_X_L = 16,
    parameter int unsigned PADDLE_X_R = 616,
    parameter int unsigned SPEED      = 2,
    parameter int unsigned MAX_SPEED  = 6,
    parameter int unsigned HOLD_TICKS = 60,
    parameter int unsigned MAX_SCORE  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pong_ball_ctrl_if.slave   bus
);
    localparam int unsigned CW    = 11;
    localparam int unsigned CX    = (SCREEN_W - BALL_SIZE) / 2;
    localparam int unsigned CY    = (SCREEN_H - BALL_SIZE) / 2;
    localparam int unsigned XMAX  = SCREEN_W - BALL_SIZE;
    localparam int unsigned YMAX  = SCREEN_H - BALL_SIZE;
    localparam int unsigned FR    = PADDLE_X_R - BALL_SIZE;
    localparam int unsigned FL    = PADDLE_X_L + PADDLE_W;
    localparam int unsigned HW    = $clog2(HOLD_TICKS + 1);
    localparam int unsigned SPD_C = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
    localparam int unsigned SW    = $clog2(SPD_C + 1);

    typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_e;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            dir_x_q, dir_x_d;   // 1 = right
    logic            dir_y_q, dir_y_d;   // 1 = down
    logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
    logic            hit_q, hit_d, miss_q, miss_d, go_q, go_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [SW-1:0]   spd;

    logic [CW-1:0]   xw, yw, s, lpw, rpw;
    logic            l_ovl, r_ovl;

    assign xw  = CW'(x_q);
    assign yw  = CW'(y_q);
    assign s   = CW'(spd);
    assign lpw = CW'(bus.lpad_y_i);
    assign rpw = CW'(bus.rpad_y_i);

    // Overlap uses the pre-update y so both axes see the same ball snapshot.
    assign l_ovl = (yw + CW'(BALL_SIZE) > lpw) && (yw < lpw + CW'(PADDLE_H));
    assign r_ovl = (yw + CW'(BALL_SIZE) > rpw) && (yw < rpw + CW'(PADDLE_H));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hold_d    = hold_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;

        case (state_q)
            IDLE: begin
                x_d = 10'(CX);
                y_d = 10'(CY);
                if (bus.serve_i && !go_q) state_d = MOVE;
            end
            MOVE: begin
                if (bus.strobe_i) begin
                    if (dir_y_q) begin
                        if (yw + s >= CW'(YMAX)) begin
                            y_d     = 10'(YMAX);
                            dir_y_d = 1'b0;
                        end else y_d = 10'(yw + s);
                    end else begin
                        if (yw <= s) begin
                            y_d     = 10'd0;
                            dir_y_d = 1'b1;
                        end else y_d = 10'(yw - s);
                    end

                    if (dir_x_q) begin
                        if (xw <= CW'(FR) && xw + s >= CW'(FR) && r_ovl) begin
                            x_d     = 10'(FR);
                            dir_x_d = 1'b0;
                            hit_d   = 1'b1;
                        end else if (xw + s >= CW'(XMAX)) begin
                            x_d     = 10'(XMAX);
                            miss_d  = 1'b1;
                            dir_x_d = 1'b1;
                            state_d = SCORED;
                            if (score_l_q < 4'(MAX_SCORE)) score_l_d = score_l_q + 4'd1;
                        end else x_d = 10'(xw + s);
                    end else begin
                        if (xw >= CW'(FL) && xw - s <= CW'(FL) && l_ovl) begin
                            x_d     = 10'(FL);
                            dir_x_d = 1'b1;
                            hit_d   = 1'b1;
                        end else if (xw <= s) begin
                            x_d     = 10'd0;
                            miss_d  = 1'b1;
                            dir_x_d = 1'b0;
                            state_d = SCORED;
                            if (score_r_q < 4'(MAX_SCORE)) score_r_d = score_r_q + 4'd1;
                        end else x_d = 10'(xw - s);
                    end
                end
            end
            SCORED: begin
                if (bus.strobe_i) begin
                    if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        hold_d  = '0;
                        x_d     = 10'(CX);
                        y_d     = 10'(CY);
                        state_d = IDLE;
                    end else hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        go_d = go_q || (score_l_d == 4'(MAX_SCORE)) || (score_r_d == 4'(MAX_SCORE));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            x_q       <= 10'(CX);
            y_q       <= 10'(CY);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            go_q      <= go_d;
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [SW-1:0] spd_q, spd_d;

    always_comb begin
        spd_d = spd_q;
        if (hit_d)       spd_d = (spd_q >= SW'(MAX_SPEED)) ? SW'(MAX_SPEED) : spd_q + SW'(1);
        else if (miss_d) spd_d = SW'(SPEED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) spd_q <= SW'(SPEED);
        else       spd_q <= spd_d;
    end

    assign spd = spd_q;
`else
    assign spd = SW'(SPEED);
`endif

    assign bus.ball_x_o    = x_q;
    assign bus.ball_y_o    = y_q;
    assign bus.score_l_o   = score_l_q;
    assign bus.score_r_o   = score_r_q;
    assign bus.hit_o       = hit_q;
    assign bus.miss_o      = miss_q;
    assign bus.game_over_o = go_q;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: vector table for the main trajectory plus scoring/reset sequences.
module tb_pong_ball_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pong_ball_ctrl_if bus ();

    pong_ball_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit do_rst;
        bit serve;
        int n;
        int lpad;
        int rpad;
        int x;
        int y;
        bit hit;
        bit miss;
        int sl;
        int sr;
        bit go;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit sv, input int n, input int lp, input int rp,
                       input int x, input int y, input bit h, input bit m,
                       input int sl, input int sr, input bit go);
        vec_t v;
        v.do_rst = r; v.serve = sv; v.n = n; v.lpad = lp; v.rpad = rp;
        v.x = x; v.y = y; v.hit = h; v.miss = m; v.sl = sl; v.sr = sr; v.go = go;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y, input bit h, input bit m,
                             input int sl, input int sr, input bit go);
        check({tag, " ball_x"},    int'(bus.ball_x_o),    x);
        check({tag, " ball_y"},    int'(bus.ball_y_o),    y);
        check({tag, " hit"},       int'(bus.hit_o),       int'(h));
        check({tag, " miss"},      int'(bus.miss_o),      int'(m));
        check({tag, " score_l"},   int'(bus.score_l_o),   sl);
        check({tag, " score_r"},   int'(bus.score_r_o),   sr);
        check({tag, " game_over"}, int'(bus.game_over_o), int'(go));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.strobe_i = 1'b0;
        bus.serve_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            bus.strobe_i = 1'b1;
            @(negedge clk);
            bus.strobe_i = 1'b0;
        end
    endtask

    // Serve request coinciding with a strobe: the strobe must not move the ball.
    task automatic serve_cycle();
        bus.serve_i  = 1'b1;
        bus.strobe_i = 1'b1;
        @(negedge clk);
        bus.serve_i  = 1'b0;
        bus.strobe_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.strobe_i = 1'b0;
        bus.serve_i  = 1'b0;
        bus.lpad_y_i = 10'd0;
        bus.rpad_y_i = 10'd0;

        //   rst sv  n    lp   rp    x    y  hit miss sl sr go
        add(1, 0,   0, 140, 400, 316, 236, 0, 0, 0, 0, 0);
        add(0, 0,  10, 140, 400, 316, 236, 0, 0, 0, 0, 0);
        add(0, 1,   0, 140, 400, 316, 236, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400, 318, 238, 0, 0, 0, 0, 0);
        add(0, 0, 117, 140, 400, 552, 472, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400, 554, 470, 0, 0, 0, 0, 0);
        add(0, 0,  26, 140, 400, 606, 418, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400, 608, 416, 1, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400, 606, 414, 0, 0, 0, 0, 0);
        add(0, 0, 206, 140, 400, 194,   2, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400, 192,   0, 0, 0, 0, 0, 0);
        add(0, 0,  83, 140, 400,  26, 166, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400,  24, 168, 1, 0, 0, 0, 0);
        add(0, 0,   1, 140, 400,  26, 170, 0, 0, 0, 0, 0);
        add(1, 1, 157, 140, 1000, 630, 394, 0, 0, 0, 0, 0);
        add(0, 0,   1, 140, 1000, 632, 392, 0, 1, 1, 0, 0);
        add(0, 0,  59, 140, 1000, 632, 392, 0, 0, 1, 0, 0);
        add(0, 0,   1, 140, 1000, 316, 236, 0, 0, 1, 0, 0);
        add(0, 0,   3, 140, 1000, 316, 236, 0, 0, 1, 0, 0);
        add(0, 1,   1, 140, 1000, 318, 234, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            bus.lpad_y_i = 10'(vecs[i].lpad);
            bus.rpad_y_i = 10'(vecs[i].rpad);
            if (vecs[i].do_rst) do_reset();
            if (vecs[i].serve) serve_cycle();
            tick(vecs[i].n);
            check_all(tag, vecs[i].x, vecs[i].y, vecs[i].hit, vecs[i].miss,
                      vecs[i].sl, vecs[i].sr, vecs[i].go);
        end

        // Left player scores nine straight points; game_over then locks out serve.
        bus.rpad_y_i = 10'd1000;
        do_reset();
        for (int p = 1; p <= 9; p++) begin
            serve_cycle();
            tick(158);
            check($sformatf("pt%0d miss", p), int'(bus.miss_o), 1);
            check($sformatf("pt%0d score_l", p), int'(bus.score_l_o), p);
            check($sformatf("pt%0d game_over", p), int'(bus.game_over_o), (p == 9) ? 1 : 0);
            tick(60);
        end
        check_all("gameover idle", 316, 236, 0, 0, 9, 0, 1);
        serve_cycle();
        tick(5);
        check_all("gameover serve", 316, 236, 0, 0, 9, 0, 1);

        // Asynchronous reset mid-flight, sampled before any clock edge.
        do_reset();
        bus.rpad_y_i = 10'd400;
        serve_cycle();
        tick(20);
        check_all("pre async", 356, 276, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_all("async rst", 316, 236, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
